// File: rtl/wptr_full_ctrl_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion used by both the write-side
// and read-side pointer controllers.
package wptr_full_ctrl_pkg;

    localparam int MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        for (int i = 0; i < MAX_PTR_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module gray2bin #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller of an asynchronous FIFO: binary/Gray write
// pointer, full / almost-full / level flags and a sticky overflow flag.
module wptr_full_ctrl
    import wptr_full_ctrl_pkg::*;
#(
    parameter int PTR_WIDTH    = 5,
    parameter int AFULL_THRESH = 28
) (
    input  logic                 wr_clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic                 clr_ovf_i,
    input  logic [PTR_WIDTH:0]   rp2wp_gray_i,
    output logic                 wr_accept_o,
    output logic [PTR_WIDTH-1:0] waddr_o,
    output logic [PTR_WIDTH:0]   wptr_gray_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [PTR_WIDTH:0]   wr_level_o,
    output logic                 overflow_o
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rgray_full_cmp;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          afull_next;

    // Handshake: wr_en_i is the producer's request and wr_accept_o marks the cycles in
    // which the write really happens; a request while full is dropped and flagged.
    assign wr_accept_o = wr_en_i & ~full_o;
    assign waddr_o     = wbin[PTR_WIDTH-1:0];

    gray2bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (rp2wp_gray_i),
        .bin  (rbin)
    );

    // Full when the write pointer is exactly one lap ahead: in Gray code that is the
    // read pointer with its two top bits inverted.
    always_comb begin
        wbin_next      = wbin + PW'(wr_accept_o);
        wgray_next     = PW'(bin2gray(MAX_PTR_W'(wbin_next)));
        rgray_full_cmp = {~rp2wp_gray_i[PW-1:PW-2], rp2wp_gray_i[PW-3:0]};
        full_next      = (wgray_next == rgray_full_cmp);
        level_next     = wbin_next - rbin;
        afull_next     = (level_next >= AFULL_LVL);
    end

    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbin          <= '0;
            wptr_gray_o   <= '0;
            full_o        <= 1'b0;
            almost_full_o <= 1'b0;
            wr_level_o    <= '0;
            overflow_o    <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            wptr_gray_o   <= wgray_next;
            full_o        <= full_next;
            almost_full_o <= afull_next;
            wr_level_o    <= level_next;
            // A new overflow wins over a concurrent clear.
            if (wr_en_i && full_o) begin
                overflow_o <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Randomized and directed bench for wptr_full_ctrl against a write/read count model.
module tb_wptr_full_ctrl;

    localparam int PTR_WIDTH = 5;
    localparam int DEPTH     = 32;
    localparam int AFULL     = 28;

    logic       wr_clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       wr_en_i = 1'b0;
    logic       clr_ovf_i = 1'b0;
    logic [5:0] rp2wp_gray_i = '0;
    logic       wr_accept_o;
    logic [4:0] waddr_o;
    logic [5:0] wptr_gray_o;
    logic       full_o;
    logic       almost_full_o;
    logic [5:0] wr_level_o;
    logic       overflow_o;

    wptr_full_ctrl #(
        .PTR_WIDTH    (PTR_WIDTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .wr_clk_i      (wr_clk_i),
        .rst_i         (rst_i),
        .wr_en_i       (wr_en_i),
        .clr_ovf_i     (clr_ovf_i),
        .rp2wp_gray_i  (rp2wp_gray_i),
        .wr_accept_o   (wr_accept_o),
        .waddr_o       (waddr_o),
        .wptr_gray_o   (wptr_gray_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .wr_level_o    (wr_level_o),
        .overflow_o    (overflow_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: total words written and read since reset, plus sticky overflow.
    int wr_total = 0;
    int rd_total = 0;
    bit m_ovf = 1'b0;
    bit m_full = 1'b0;
    bit exp_acc;
    bit obs_acc;

    function automatic logic [5:0] to_gray(input int count);
        logic [5:0] b;
        b = count[5:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int exp_level();
        return wr_total - rd_total;
    endfunction

    // Drives one cycle (inputs set away from the edge) and advances the model.
    task automatic drive_cycle(input bit we, input bit clr);
        wr_en_i      = we;
        clr_ovf_i    = clr;
        rp2wp_gray_i = to_gray(rd_total);
        #1;
        exp_acc = we && !m_full;
        obs_acc = wr_accept_o;
        @(posedge wr_clk_i);
        if (exp_acc) wr_total++;
        if (we && m_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_full = (exp_level() == DEPTH);
        #1;
        wr_en_i   = 1'b0;
        clr_ovf_i = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        rst_i        = 1'b1;
        wr_en_i      = 1'b0;
        rp2wp_gray_i = '0;
        wr_total = 0;
        rd_total = 0;
        m_ovf    = 1'b0;
        m_full   = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge wr_clk_i);
        #3;
        rst_i = 1'b0;
        @(posedge wr_clk_i);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0);
        apply_reset();
        checks++;
        if ({wptr_gray_o, full_o, almost_full_o, wr_level_o, overflow_o, waddr_o} !== '0) begin
            errors++;
            $display("FAIL reset_async: gray=%b full=%b afull=%b level=%0d ovf=%b waddr=%0d want all 0",
                     wptr_gray_o, full_o, almost_full_o, wr_level_o, overflow_o, waddr_o);
        end
        wr_en_i = 1'b1;
        #1;
        checks++;
        if (wr_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_accept: got %b want 1", wr_accept_o);
        end
        wr_en_i = 1'b0;
        release_reset();
        checks++;
        if (wr_level_o !== 6'd0 || waddr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_release: level=%0d waddr=%0d want 0 0", wr_level_o, waddr_o);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1'b1, 1'b0);
            checks++;
            if (almost_full_o !== (i >= AFULL) || full_o !== (i == DEPTH) || wr_level_o !== 6'(i)) begin
                errors++;
                $display("FAIL fill_%0d: afull=%b full=%b level=%0d want %b %b %0d",
                         i, almost_full_o, full_o, wr_level_o, i >= AFULL, i == DEPTH, i);
            end
        end
        checks++;
        if (wptr_gray_o !== 6'b110000) begin
            errors++;
            $display("FAIL fill_gray: got %b want 110000", wptr_gray_o);
        end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1, 1'b0);
        checks++;
        if (obs_acc !== 1'b0 || waddr_o !== 5'd0 || wptr_gray_o !== 6'b110000 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: acc=%b waddr=%0d gray=%b ovf=%b want 0 0 110000 1",
                     obs_acc, waddr_o, wptr_gray_o, overflow_o);
        end
        drive_cycle(1'b1, 1'b1);
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_clr: got %b want 1", overflow_o);
        end
        drive_cycle(1'b0, 1'b1);
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b want 0", overflow_o);
        end
    endtask

    task automatic test_drain_wrap();
        rd_total = DEPTH;
        drive_cycle(1'b0, 1'b0);
        checks++;
        if (full_o !== 1'b0 || wr_level_o !== 6'd0 || almost_full_o !== 1'b0) begin
            errors++;
            $display("FAIL drain: full=%b level=%0d afull=%b want 0 0 0", full_o, wr_level_o, almost_full_o);
        end
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0);
        checks++;
        if (full_o !== 1'b1 || waddr_o !== 5'd0 || wptr_gray_o !== 6'b000000 || wr_level_o !== 6'd32) begin
            errors++;
            $display("FAIL wrap: full=%b waddr=%0d gray=%b level=%0d want 1 0 000000 32",
                     full_o, waddr_o, wptr_gray_o, wr_level_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        release_reset();
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0);
        rd_total++;
        drive_cycle(1'b1, 1'b0);
        checks++;
        if (wr_level_o !== 6'd10 || obs_acc !== 1'b1) begin
            errors++;
            $display("FAIL simul_wr_rd: level=%0d acc=%b want 10 1", wr_level_o, obs_acc);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        release_reset();
        for (int i = 0; i < 15; i++) drive_cycle(1'b1, 1'b0);
        checks++;
        if (wr_level_o !== 6'd15) begin
            errors++;
            $display("FAIL mid_pre: level=%0d want 15", wr_level_o);
        end
        apply_reset();
        checks++;
        if (wr_level_o !== 6'd0 || waddr_o !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset: level=%0d waddr=%0d want 0 0", wr_level_o, waddr_o);
        end
        release_reset();
        wr_en_i = 1'b1;
        #1;
        checks++;
        if (waddr_o !== 5'd0 || wr_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_addr: waddr=%0d acc=%b want 0 1", waddr_o, wr_accept_o);
        end
        drive_cycle(1'b1, 1'b0);
        checks++;
        if (waddr_o !== 5'd1 || wr_level_o !== 6'd1) begin
            errors++;
            $display("FAIL mid_second_addr: waddr=%0d level=%0d want 1 1", waddr_o, wr_level_o);
        end
    endtask

    task automatic test_random();
        int lvl;
        apply_reset();
        release_reset();
        for (int i = 0; i < 400; i++) begin
            if (rd_total < wr_total && $urandom_range(0, 99) < 40)
                rd_total += $urandom_range(1, wr_total - rd_total);
            drive_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 9) == 0);
            lvl = exp_level();
            checks++;
            if (obs_acc !== exp_acc || wr_level_o !== 6'(lvl) || full_o !== (lvl == DEPTH) ||
                almost_full_o !== (lvl >= AFULL) || overflow_o !== m_ovf ||
                wptr_gray_o !== to_gray(wr_total) || waddr_o !== 5'(wr_total)) begin
                errors++;
                $display("FAIL random_%0d: acc=%b lvl=%0d full=%b af=%b ovf=%b g=%b a=%0d want %b %0d %b %b %b %b %0d",
                         i, obs_acc, wr_level_o, full_o, almost_full_o, overflow_o, wptr_gray_o, waddr_o,
                         exp_acc, lvl, lvl == DEPTH, lvl >= AFULL, m_ovf, to_gray(wr_total), wr_total % DEPTH);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        #12;
        rst_i = 1'b0;
        @(posedge wr_clk_i);
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_drain_wrap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
